// File: rtl/fp_unit_core.sv
// Binary32 add/sub/mul/compare execute unit with a one-cycle registered response.
// Define FP_UNIT_CMP_EN to build the fcmp datapath; otherwise fcmp is reported as unsupported.
package fp_wire;
    typedef struct packed {
        logic       fmadd;
        logic       fmsub;
        logic       fnmadd;
        logic       fnmsub;
        logic       fadd;
        logic       fsub;
        logic       fmul;
        logic       fdiv;
        logic       fsqrt;
        logic       fsgnj;
        logic       fcmp;
        logic       fmax;
        logic       fclass;
        logic       fmv_i2f;
        logic       fmv_f2i;
        logic       fcvt_f2f;
        logic       fcvt_i2f;
        logic       fcvt_f2i;
        logic [1:0] fcvt_op;
    } fp_operation_type;

    typedef struct packed {
        logic [63:0]      data1;
        logic [63:0]      data2;
        logic [63:0]      data3;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        fp_operation_type op;
        logic             enable;
    } fp_exe_in_type;

    typedef struct packed {
        fp_exe_in_type fp_exe_i;
    } fp_unit_in_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_exe_out_type;

    typedef struct packed {
        fp_exe_out_type fp_exe_o;
    } fp_unit_out_type;
endpackage

module fp_unit_core
    import fp_wire::*;
(
    input  logic            clock,
    input  logic            reset,
    input  fp_unit_in_type  fp_unit_i,
    output fp_unit_out_type fp_unit_o
);
    localparam int unsigned XW = 50;
    localparam int unsigned SW = 26;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [2:0]  RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

    function automatic logic round_inc(input logic [2:0] mode, input logic s,
                                       input logic lsb, input logic g, input logic st);
        case (mode)
            RTZ:     round_inc = 1'b0;
            RDN:     round_inc = s & (g | st);
            RUP:     round_inc = ~s & (g | st);
            RMM:     round_inc = g;
            default: round_inc = g & (st | lsb);
        endcase
    endfunction

    // Leading one moved to bit XW-1, then folded to 24 bits + guard + sticky.
    function automatic logic [37:0] normalize(input logic [XW-1:0] x, input logic [11:0] ex);
        logic [5:0]    lz;
        logic [XW-1:0] xn;
        lz = 6'd0;
        for (int i = 0; i < int'(XW); i++)
            if (x[i]) lz = 6'(int'(XW) - 1 - i);
        xn = x << lz;
        normalize = {12'(ex - 12'(lz)), xn[49:26], xn[25], |xn[24:0]};
    endfunction

    // Returns {result[31:0], flags[4:0]}; sig is normalized with value 1.f * 2^(e-127).
    function automatic logic [36:0] round_pack(input logic s, input logic signed [11:0] e,
                                               input logic [SW-1:0] sig, input logic [2:0] mode);
        logic [SW-1:0] m;
        logic [4:0]    k;
        logic [7:0]    ef;
        logic [30:0]   mag;
        logic          inc, nx, tiny, to_inf;
        m  = sig;
        k  = 5'd0;
        ef = e[7:0];
        if (e <= 12'sd0) begin
            k  = (e < -12'sd24) ? 5'd26 : 5'(12'sd1 - e);
            m  = (sig >> k) | SW'(|(sig & ~({SW{1'b1}} << k)));
            ef = 8'd0;
        end
        inc    = round_inc(mode, s, m[2], m[1], m[0]);
        nx     = m[1] | m[0];
        mag    = {ef, m[24:2]} + 31'(inc);
        // Tiny unless rounding with unbounded exponent reaches the smallest normal.
        tiny   = (e < 12'sd0) ||
                 (e == 12'sd0 && !(round_inc(mode, s, sig[2], sig[1], sig[0]) && &sig[25:2]));
        to_inf = (mode == RNE) || (mode == RMM) || (mode == RUP && !s) || (mode == RDN && s);
        if (e >= 12'sd255 || mag[30:23] == 8'hFF)
            round_pack = {s, to_inf ? 31'h7F800000 : 31'h7F7FFFFF, 5'b00101};
        else
            round_pack = {s, mag, 3'b000, tiny & nx, nx};
    endfunction

    logic [31:0]   a, b;
    logic [2:0]    rm;
    logic [17:0]   ops;
    logic          op_onehot;
    logic [7:0]    a_e, b_e;
    logic [23:0]   a_man, b_man;
    logic          a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic          sb_eff, swap, s_big, s_sml;
    logic [7:0]    e_big, e_sml, d;
    logic [XW-1:0] x_big, x_sml, x_al, x_sum;
    logic [37:0]   add_nrm, mul_nrm;
    logic [31:0]   add_res, mul_res, cmp_res, nxt_res, result_q;
    logic [4:0]    add_flg, mul_flg, cmp_flg, nxt_flg, flags_q;
    logic          mul_s, ready_q;
    logic [47:0]   prod;
    logic          unused_bits;

    assign a         = fp_unit_i.fp_exe_i.data1[31:0];
    assign b         = fp_unit_i.fp_exe_i.data2[31:0];
    assign rm        = (fp_unit_i.fp_exe_i.rm > RMM) ? RNE : fp_unit_i.fp_exe_i.rm;
    assign ops       = fp_unit_i.fp_exe_i.op[19:2];
    assign op_onehot = (ops != 18'd0) && ((ops & (ops - 18'd1)) == 18'd0);

    assign a_e    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    assign b_e    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    assign a_man  = {|a[30:23], a[22:0]};
    assign b_man  = {|b[30:23], b[22:0]};
    assign a_nan  = &a[30:23] & |a[22:0];
    assign b_nan  = &b[30:23] & |b[22:0];
    assign a_snan = a_nan & ~a[22];
    assign b_snan = b_nan & ~b[22];
    assign a_inf  = &a[30:23] & ~|a[22:0];
    assign b_inf  = &b[30:23] & ~|b[22:0];
    assign a_zero = ~|a[30:0];
    assign b_zero = ~|b[30:0];

    // Add/sub: larger magnitude stays put, smaller is aligned with a jammed sticky bit.
    always_comb begin
        sb_eff  = b[31] ^ fp_unit_i.fp_exe_i.op.fsub;
        swap    = b[30:0] > a[30:0];
        s_big   = swap ? sb_eff : a[31];
        s_sml   = swap ? a[31] : sb_eff;
        e_big   = swap ? b_e : a_e;
        e_sml   = swap ? a_e : b_e;
        d       = e_big - e_sml;
        x_big   = {1'b0, swap ? b_man : a_man, 25'b0};
        x_sml   = {1'b0, swap ? a_man : b_man, 25'b0};
        x_al    = (x_sml >> d) | XW'(|(x_sml & ~({XW{1'b1}} << d)));
        x_sum   = (s_big == s_sml) ? x_big + x_al : x_big - x_al;
        add_nrm = normalize(x_sum, 12'(e_big) + 12'd1);
        {add_res, add_flg} = round_pack(s_big, add_nrm[37:26], add_nrm[25:0], rm);
        if (a_nan | b_nan)
            {add_res, add_flg} = {QNAN, a_snan | b_snan, 4'b0};
        else if (a_inf & b_inf & (a[31] != sb_eff))
            {add_res, add_flg} = {QNAN, 5'b10000};
        else if (a_inf)
            {add_res, add_flg} = {a[31], 31'h7F800000, 5'b0};
        else if (b_inf)
            {add_res, add_flg} = {sb_eff, 31'h7F800000, 5'b0};
        else if (x_sum == '0)
            {add_res, add_flg} = {(s_big == s_sml) ? s_big : (rm == RDN), 31'b0, 5'b0};
    end

    always_comb begin
        mul_s   = a[31] ^ b[31];
        prod    = a_man * b_man;
        mul_nrm = normalize({prod, 2'b00}, 12'(a_e) + 12'(b_e) - 12'd126);
        {mul_res, mul_flg} = round_pack(mul_s, mul_nrm[37:26], mul_nrm[25:0], rm);
        if (a_nan | b_nan)
            {mul_res, mul_flg} = {QNAN, a_snan | b_snan, 4'b0};
        else if ((a_inf & b_zero) | (b_inf & a_zero))
            {mul_res, mul_flg} = {QNAN, 5'b10000};
        else if (a_inf | b_inf)
            {mul_res, mul_flg} = {mul_s, 31'h7F800000, 5'b0};
        else if (a_zero | b_zero)
            {mul_res, mul_flg} = {mul_s, 31'b0, 5'b0};
    end

`ifdef FP_UNIT_CMP_EN
    logic both_zero, any_nan, cmp_eq, cmp_lt;

    // Compare select uses the raw rm field, so 011..111 are all invalid here.
    always_comb begin
        both_zero = a_zero & b_zero;
        any_nan   = a_nan | b_nan;
        cmp_eq    = (a == b) | both_zero;
        cmp_lt    = (a[31] != b[31]) ? (a[31] & ~both_zero)
                                     : (a[31] ? (a[30:0] > b[30:0]) : (a[30:0] < b[30:0]));
        cmp_res   = 32'd0;
        cmp_flg   = 5'b10000;
        case (fp_unit_i.fp_exe_i.rm)
            3'b010: begin
                cmp_res = {31'b0, cmp_eq & ~any_nan};
                cmp_flg = {a_snan | b_snan, 4'b0};
            end
            3'b001: begin
                cmp_res = {31'b0, cmp_lt & ~any_nan};
                cmp_flg = {any_nan, 4'b0};
            end
            3'b000: begin
                cmp_res = {31'b0, (cmp_lt | cmp_eq) & ~any_nan};
                cmp_flg = {any_nan, 4'b0};
            end
            default: ;
        endcase
    end
`else
    assign cmp_res = QNAN;
    assign cmp_flg = 5'b10000;
`endif

    always_comb begin
        nxt_res = QNAN;
        nxt_flg = 5'b10000;
        if (fp_unit_i.fp_exe_i.fmt == 2'd0 && op_onehot) begin
            if (fp_unit_i.fp_exe_i.op.fadd | fp_unit_i.fp_exe_i.op.fsub) begin
                nxt_res = add_res;
                nxt_flg = add_flg;
            end else if (fp_unit_i.fp_exe_i.op.fmul) begin
                nxt_res = mul_res;
                nxt_flg = mul_flg;
            end else if (fp_unit_i.fp_exe_i.op.fcmp) begin
                nxt_res = cmp_res;
                nxt_flg = cmp_flg;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q  <= 1'b0;
            result_q <= 32'd0;
            flags_q  <= 5'd0;
        end else begin
            ready_q <= fp_unit_i.fp_exe_i.enable;
            if (fp_unit_i.fp_exe_i.enable) begin
                result_q <= nxt_res;
                flags_q  <= nxt_flg;
            end
        end
    end

    assign fp_unit_o   = {32'd0, result_q, flags_q, ready_q};
    assign unused_bits = ^{fp_unit_i.fp_exe_i.data1[63:32], fp_unit_i.fp_exe_i.data2[63:32],
                           fp_unit_i.fp_exe_i.data3, fp_unit_i.fp_exe_i.op.fcvt_op};
endmodule

// File: tb/tb_fp_unit_core.sv
// Scoreboard bench for fp_unit_core: directed vectors push expectations, a monitor checks responses.
module tb_fp_unit_core;
    import fp_wire::*;

    localparam logic [17:0] OP_FADD = 18'd1 << 13;
    localparam logic [17:0] OP_FSUB = 18'd1 << 12;
    localparam logic [17:0] OP_FMUL = 18'd1 << 11;
    localparam logic [17:0] OP_FDIV = 18'd1 << 10;
    localparam logic [17:0] OP_FCMP = 18'd1 << 7;
    localparam logic [31:0] QN      = 32'h7FC00000;
`ifdef FP_UNIT_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    typedef struct {
        logic [63:0] res;
        logic [4:0]  flg;
        int          id;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    fp_unit_in_type  req;
    fp_unit_out_type rsp;
    exp_t            q[$];
    exp_t            cur;
    int              npass = 0;
    int              nchk  = 0;

    fp_unit_core dut (
        .clock    (clock),
        .reset    (reset),
        .fp_unit_i(req),
        .fp_unit_o(rsp)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            npass++;
    endtask

    task automatic issue(input int id, input logic [17:0] op, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [2:0] rm, input logic [1:0] fmt,
                         input logic [31:0] er, input logic [4:0] ef);
        @(posedge clock);
        #1;
        req.fp_exe_i.data1  = d1;
        req.fp_exe_i.data2  = d2;
        req.fp_exe_i.data3  = 64'd0;
        req.fp_exe_i.fmt    = fmt;
        req.fp_exe_i.rm     = rm;
        req.fp_exe_i.op     = {op, 2'b00};
        req.fp_exe_i.enable = 1'b1;
        q.push_back('{res: {32'd0, er}, flg: ef, id: id});
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && rsp.fp_exe_o.ready) begin
            if (q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                cur = q.pop_front();
                check($sformatf("vec%0d_result", cur.id), rsp.fp_exe_o.result, cur.res);
                check($sformatf("vec%0d_flags", cur.id), 64'(rsp.fp_exe_o.flags), 64'(cur.flg));
            end
        end
    end

    initial begin
        req   = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_ready", 64'(rsp.fp_exe_o.ready), 64'd0);
        check("rst_result", rsp.fp_exe_o.result, 64'd0);
        check("rst_flags", 64'(rsp.fp_exe_o.flags), 64'd0);

        issue(1,  OP_FADD, 64'h3F800000, 64'h40000000, 3'd0, 2'd0, 32'h40400000, 5'h00);
        issue(2,  OP_FSUB, 64'h3F800000, 64'h3F800000, 3'd2, 2'd0, 32'h80000000, 5'h00);
        issue(3,  OP_FSUB, 64'h3F800000, 64'h3F800000, 3'd0, 2'd0, 32'h00000000, 5'h00);
        issue(4,  OP_FMUL, 64'h7F7FFFFF, 64'h40000000, 3'd0, 2'd0, 32'h7F800000, 5'h05);
        issue(5,  OP_FMUL, 64'h7F7FFFFF, 64'h40000000, 3'd1, 2'd0, 32'h7F7FFFFF, 5'h05);
        issue(6,  OP_FMUL, 64'h7F800000, 64'h00000000, 3'd0, 2'd0, QN,           5'h10);
        issue(7,  OP_FMUL, 64'h00800000, 64'h3F000000, 3'd0, 2'd0, 32'h00400000, 5'h00);
        issue(8,  OP_FCMP, 64'h7FC00000, 64'h3F800000, 3'd1, 2'd0, CMP ? 32'd0 : QN, 5'h10);
        issue(9,  OP_FCMP, 64'h7FC00000, 64'h3F800000, 3'd2, 2'd0, CMP ? 32'd0 : QN,
              CMP ? 5'h00 : 5'h10);
        issue(10, OP_FDIV, 64'h3F800000, 64'h40000000, 3'd0, 2'd0, QN,           5'h10);
        issue(11, OP_FADD, 64'h3F800000, 64'h33800000, 3'd0, 2'd0, 32'h3F800000, 5'h01);
        issue(12, OP_FADD, 64'h3F800000, 64'h33800000, 3'd3, 2'd0, 32'h3F800001, 5'h01);
        issue(13, OP_FMUL, 64'h7F800001, 64'h3F800000, 3'd0, 2'd0, QN,           5'h10);
        issue(14, OP_FSUB, 64'h7F800000, 64'h7F800000, 3'd0, 2'd0, QN,           5'h10);
        issue(15, OP_FMUL, 64'h00800001, 64'h3F000000, 3'd0, 2'd0, 32'h00400000, 5'h03);
        issue(16, OP_FCMP, 64'h3F800000, 64'h3F800000, 3'd2, 2'd0, CMP ? 32'd1 : QN,
              CMP ? 5'h00 : 5'h10);
        issue(17, OP_FCMP, 64'h80000000, 64'h00000000, 3'd1, 2'd0, CMP ? 32'd0 : QN,
              CMP ? 5'h00 : 5'h10);
        issue(18, OP_FCMP, 64'h80000000, 64'h00000000, 3'd0, 2'd0, CMP ? 32'd1 : QN,
              CMP ? 5'h00 : 5'h10);
        issue(19, OP_FCMP, 64'h3F800000, 64'h40000000, 3'd3, 2'd0, CMP ? 32'd0 : QN, 5'h10);
        issue(20, OP_FADD, 64'h7F7FFFFF, 64'h7F7FFFFF, 3'd2, 2'd0, 32'h7F7FFFFF, 5'h05);
        issue(21, OP_FADD, 64'h3F800000, 64'h40000000, 3'd0, 2'd1, QN,           5'h10);
        issue(22, 18'd0,   64'h3F800000, 64'h40000000, 3'd0, 2'd0, QN,           5'h10);
        issue(23, OP_FADD | OP_FMUL, 64'h3F800000, 64'h40000000, 3'd0, 2'd0, QN, 5'h10);
        issue(24, OP_FADD, 64'hDEADBEEF_3F800000, 64'h12345678_40000000, 3'd7, 2'd0,
              32'h40400000, 5'h00);
        issue(25, OP_FSUB, 64'h00800001, 64'h00800000, 3'd0, 2'd0, 32'h00000001, 5'h00);

        @(posedge clock);
        #1;
        req.fp_exe_i.enable = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("idle_ready", 64'(rsp.fp_exe_o.ready), 64'd0);
        check("idle_hold_result", rsp.fp_exe_o.result, 64'h00000001);

        // A request captured together with reset must never produce a ready pulse.
        req.fp_exe_i.op     = {OP_FADD, 2'b00};
        req.fp_exe_i.data1  = 64'h3F800000;
        req.fp_exe_i.data2  = 64'h40000000;
        req.fp_exe_i.enable = 1'b1;
        reset               = 1'b1;
        @(posedge clock);
        #1;
        reset               = 1'b0;
        req.fp_exe_i.enable = 1'b0;
        check("rst_mid_ready", 64'(rsp.fp_exe_o.ready), 64'd0);
        @(posedge clock);
        #1;
        check("rst_mid_ready_next", 64'(rsp.fp_exe_o.ready), 64'd0);
        check("rst_mid_result", rsp.fp_exe_o.result, 64'd0);
        check("pending_responses", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
